// File: rtl/geofence_pkg.sv
// Shared widths and FSM state type for the geofence transmitter and its sqrt engine.
package geofence_pkg;

   localparam int unsigned COORD_W  = 10;
   localparam int unsigned DIST_W   = 11;
   localparam int unsigned SQ_W     = 21;
   localparam int unsigned N_ANCHOR = 6;

   localparam logic [2:0] IDX_OBJECT  = 3'd6;
   localparam logic [2:0] LAST_ANCHOR = 3'd5;

   typedef enum logic [2:0] {
      StIdle,
      StSq,
      StRoot,
      StArmed,
      StSend,
      StWaitRes
   } state_e;

endpackage

// File: rtl/isqrt_seq.sv
// Restoring bitwise integer square root, one root bit per cycle.
// The first bit is resolved on the start edge, so done pulses 11 cycles after start.
module isqrt_seq
   import geofence_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [SQ_W-1:0]   value,
   output logic [DIST_W-1:0] root,
   output logic [DIST_W:0]   remainder,
   output logic              done
);

   localparam int unsigned RAD_W     = SQ_W + 1;
   localparam int unsigned TRY_W     = DIST_W + 3;
   localparam logic [3:0]  LAST_ITER = 4'(DIST_W - 1);

   logic [RAD_W-1:0]  rad_q, rad_src;
   logic [DIST_W-1:0] root_q, root_src, root_nxt;
   logic [DIST_W:0]   rem_q, rem_src, rem_nxt;
   logic [TRY_W-1:0]  rem_try, trial;
   logic [3:0]        cnt_q;
   logic              active_q, done_q, ge;

   always_comb begin
      rad_src  = start ? {1'b0, value} : rad_q;
      root_src = start ? '0 : root_q;
      rem_src  = start ? '0 : rem_q;
      rem_try  = {rem_src, rad_src[RAD_W-1 -: 2]};
      trial    = {1'b0, root_src, 2'b01};
      ge       = (rem_try >= trial);
      root_nxt = {root_src[DIST_W-2:0], ge};
      // The remainder never exceeds 2*root, so the low bits of the difference suffice.
      rem_nxt  = ge ? (rem_try[DIST_W:0] - trial[DIST_W:0]) : rem_try[DIST_W:0];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rad_q    <= '0;
         root_q   <= '0;
         rem_q    <= '0;
         cnt_q    <= '0;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start || active_q) begin
            rad_q    <= {rad_src[RAD_W-3:0], 2'b00};
            root_q   <= root_nxt;
            rem_q    <= rem_nxt;
            cnt_q    <= start ? 4'd1 : cnt_q + 4'd1;
            active_q <= 1'b1;
            if (!start && cnt_q == LAST_ITER) begin
               active_q <= 1'b0;
               done_q   <= 1'b1;
            end
         end
      end
   end

   assign root      = root_q;
   assign remainder = rem_q;
   assign done      = done_q;

endmodule

// File: rtl/geofence_tx.sv
// Host-loaded transmitter that computes anchor distances and streams X/Y/R to the evaluator.
// Define GEOFENCE_TX_ROUND_EN to round R to nearest instead of truncating.
module geofence_tx
   import geofence_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               wr_en,
   input  logic [2:0]         wr_idx,
   input  logic [COORD_W-1:0] wr_x,
   input  logic [COORD_W-1:0] wr_y,
   input  logic               start,
   output logic               busy,
   output logic [COORD_W-1:0] X,
   output logic [COORD_W-1:0] Y,
   output logic [DIST_W-1:0]  R,
   input  logic               fence_valid,
   input  logic               fence_is_inside,
   output logic               result_valid,
   output logic               result_inside
);

`ifdef GEOFENCE_TX_ROUND_EN
   localparam bit RoundEn = 1'b1;
`else
   localparam bit RoundEn = 1'b0;
`endif

   state_e             state_q;
   logic [COORD_W-1:0] ax_q [N_ANCHOR];
   logic [COORD_W-1:0] ay_q [N_ANCHOR];
   logic [DIST_W-1:0]  r_q  [N_ANCHOR];
   logic [COORD_W-1:0] ox_q, oy_q;
   logic [2:0]         k_q, slot_q;

   logic [COORD_W-1:0]   dx, dy;
   logic [2*COORD_W-1:0] dx2, dy2;
   logic [SQ_W-1:0]      sq;
   logic                 sqrt_start, sqrt_done, round_up;
   logic [DIST_W-1:0]    root, root_final;
   logic [DIST_W:0]      remainder;

   always_comb begin
      dx  = (ax_q[k_q] >= ox_q) ? ax_q[k_q] - ox_q : ox_q - ax_q[k_q];
      dy  = (ay_q[k_q] >= oy_q) ? ay_q[k_q] - oy_q : oy_q - ay_q[k_q];
      dx2 = {{COORD_W{1'b0}}, dx} * {{COORD_W{1'b0}}, dx};
      dy2 = {{COORD_W{1'b0}}, dy} * {{COORD_W{1'b0}}, dy};
      sq  = {1'b0, dx2} + {1'b0, dy2};
   end

   assign sqrt_start = (state_q == StSq);
   // remainder > root is exactly sq > root^2 + root, i.e. the fractional part is at least one half.
   assign round_up   = RoundEn && (remainder > {1'b0, root});
   assign root_final = root + {{(DIST_W-1){1'b0}}, round_up};

   isqrt_seq u_isqrt (
      .clk       (clk),
      .reset     (reset),
      .start     (sqrt_start),
      .value     (sq),
      .root      (root),
      .remainder (remainder),
      .done      (sqrt_done)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= StIdle;
         k_q           <= '0;
         slot_q        <= '0;
         ox_q          <= '0;
         oy_q          <= '0;
         X             <= '0;
         Y             <= '0;
         R             <= '0;
         busy          <= 1'b0;
         result_valid  <= 1'b0;
         result_inside <= 1'b0;
         for (int i = 0; i < N_ANCHOR; i++) begin
            ax_q[i] <= '0;
            ay_q[i] <= '0;
            r_q[i]  <= '0;
         end
      end else begin
         result_valid <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (wr_en) begin
                  if (wr_idx == IDX_OBJECT) begin
                     ox_q <= wr_x;
                     oy_q <= wr_y;
                  end else if (wr_idx < IDX_OBJECT) begin
                     ax_q[wr_idx] <= wr_x;
                     ay_q[wr_idx] <= wr_y;
                  end
               end
               if (start) begin
                  k_q     <= '0;
                  busy    <= 1'b1;
                  state_q <= StSq;
               end
            end
            StSq: state_q <= StRoot;
            StRoot: begin
               if (sqrt_done) begin
                  r_q[k_q] <= root_final;
                  if (k_q == LAST_ANCHOR) begin
                     state_q <= StArmed;
                  end else begin
                     k_q     <= k_q + 3'd1;
                     state_q <= StSq;
                  end
               end
            end
            StArmed: begin
               // Slot 0 goes out on the valid edge itself so it is on the bus in window cycle 0.
               if (fence_valid) begin
                  X       <= ax_q[0];
                  Y       <= ay_q[0];
                  R       <= r_q[0];
                  slot_q  <= 3'd1;
                  state_q <= StSend;
               end
            end
            StSend: begin
               if (slot_q == 3'(N_ANCHOR)) begin
                  X       <= '0;
                  Y       <= '0;
                  R       <= '0;
                  state_q <= StWaitRes;
               end else begin
                  X      <= ax_q[slot_q];
                  Y      <= ay_q[slot_q];
                  R      <= r_q[slot_q];
                  slot_q <= slot_q + 3'd1;
               end
            end
            StWaitRes: begin
               if (fence_valid) begin
                  result_inside <= fence_is_inside;
                  result_valid  <= 1'b1;
                  busy          <= 1'b0;
                  state_q       <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_geofence_tx.sv
// Self-checking bench for geofence_tx with a distance model and a distance-based evaluator model.
`timescale 1ns/1ps
module tb_geofence_tx;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        wr_en = 1'b0;
   logic [2:0]  wr_idx = '0;
   logic [9:0]  wr_x = '0;
   logic [9:0]  wr_y = '0;
   logic        start = 1'b0;
   logic        fence_valid = 1'b0;
   logic        fence_is_inside = 1'b0;
   logic        busy, result_valid, result_inside;
   logic [9:0]  X, Y;
   logic [10:0] R;

   int n_checks = 0;
   int n_fail   = 0;
   int tax[6], tay[6], tox, toy;
   int cap_x[6], cap_y[6], cap_r[6];

   always #5 clk = ~clk;

   geofence_tx dut (
      .clk             (clk),
      .reset           (reset),
      .wr_en           (wr_en),
      .wr_idx          (wr_idx),
      .wr_x            (wr_x),
      .wr_y            (wr_y),
      .start           (start),
      .busy            (busy),
      .X               (X),
      .Y               (Y),
      .R               (R),
      .fence_valid     (fence_valid),
      .fence_is_inside (fence_is_inside),
      .result_valid    (result_valid),
      .result_inside   (result_inside)
   );

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Euclidean distance from real sqrt, corrected to the exact integer floor.
   function automatic int ref_dist(input int ax, input int ay, input int ox, input int oy);
      int dx, dy, sq, r;
      dx = ax - ox;
      dy = ay - oy;
      sq = dx * dx + dy * dy;
      r  = int'($sqrt(real'(sq)));
      while (r * r > sq) r--;
      while ((r + 1) * (r + 1) <= sq) r++;
`ifdef GEOFENCE_TX_ROUND_EN
      if (sq - r * r > r) r++;
`endif
      return r;
   endfunction

   // Evaluator: inside when the fan of triangles built from the received radii covers
   // no more than the anchor polygon's own area.
   function automatic bit eval_inside();
      real poly, tsum, a, b, c, s, p;
      int  n, ex, ey;
      poly = 0.0;
      tsum = 0.0;
      for (int i = 0; i < 6; i++) begin
         n = (i + 1) % 6;
         poly += real'(cap_x[i] * cap_y[n] - cap_x[n] * cap_y[i]);
         ex = cap_x[i] - cap_x[n];
         ey = cap_y[i] - cap_y[n];
         c  = $sqrt(real'(ex * ex + ey * ey));
         a  = real'(cap_r[i]);
         b  = real'(cap_r[n]);
         s  = (a + b + c) / 2.0;
         p  = s * (s - a) * (s - b) * (s - c);
         if (p > 0.0) tsum += $sqrt(p);
      end
      if (poly < 0.0) poly = -poly;
      poly = poly / 2.0;
      return tsum <= poly * 1.02;
   endfunction

   task automatic do_reset();
      reset = 1'b0;
      tick(2);
      reset = 1'b1;
   endtask

   task automatic load_all();
      for (int i = 0; i < 7; i++) begin
         wr_en  = 1'b1;
         wr_idx = 3'(i);
         wr_x   = 10'(i < 6 ? tax[i] : tox);
         wr_y   = 10'(i < 6 ? tay[i] : toy);
         tick();
      end
      wr_en = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Pulses fence_valid, checks the six-slot burst and the verdict handshake.
   // mode 0/1 drives that verdict, mode 2 lets the evaluator model decide.
   task automatic run_window(input string tag, input int mode);
      bit v;
      fence_valid = 1'b1;
      tick();
      fence_valid = 1'b0;
      for (int j = 0; j < 6; j++) begin
         int er;
         er = ref_dist(tax[j], tay[j], tox, toy);
         cap_x[j] = int'(X);
         cap_y[j] = int'(Y);
         cap_r[j] = int'(R);
         n_checks++;
         if (X !== 10'(tax[j]) || Y !== 10'(tay[j]) || R !== 11'(er)) begin
            n_fail++;
            $display("FAIL %s slot%0d: got X=%0d Y=%0d R=%0d, expected X=%0d Y=%0d R=%0d",
                     tag, j, X, Y, R, tax[j], tay[j], er);
         end
         tick();
      end
      n_checks++;
      if (X !== 10'd0 || Y !== 10'd0 || R !== 11'd0) begin
         n_fail++;
         $display("FAIL %s bus_after_burst: got X=%0d Y=%0d R=%0d, expected 0", tag, X, Y, R);
      end
      v = (mode == 2) ? eval_inside() : bit'(mode);
      tick(2);
      n_checks++;
      if (busy !== 1'b1 || result_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s wait_res: got busy=%b result_valid=%b, expected 1/0",
                  tag, busy, result_valid);
      end
      fence_valid     = 1'b1;
      fence_is_inside = v;
      tick();
      fence_valid     = 1'b0;
      fence_is_inside = 1'b0;
      n_checks++;
      if (result_valid !== 1'b1 || result_inside !== v || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s verdict: got valid=%b inside=%b busy=%b, expected 1/%b/0",
                  tag, result_valid, result_inside, busy, v);
      end
      tick();
      n_checks++;
      if (result_valid !== 1'b0 || result_inside !== v) begin
         n_fail++;
         $display("FAIL %s verdict_hold: got valid=%b inside=%b, expected 0/%b",
                  tag, result_valid, result_inside, v);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      wr_en = 1'b1; wr_idx = 3'd0; wr_x = 10'd55; wr_y = 10'd66;
      start = 1'b1; fence_valid = 1'b1;
      tick(3);
      wr_en = 1'b0; start = 1'b0; fence_valid = 1'b0;
      n_checks++;
      if (X !== 10'd0 || Y !== 10'd0 || R !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_bus: got X=%0d Y=%0d R=%0d, expected 0", X, Y, R);
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_busy: got %b, expected 0", busy);
      end
      n_checks++;
      if (result_valid !== 1'b0 || result_inside !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_result: got %b/%b, expected 0/0", result_valid, result_inside);
      end
      reset = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) begin tax[i] = 0; tay[i] = 0; end
      tox = 0; toy = 0;
      pulse_start();
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL start_busy: got %b, expected 1", busy);
      end
      tick(72);
      run_window("cleared_regfile", 1);
   endtask

   task automatic test_distance();
      int exp_a, exp_b;
`ifdef GEOFENCE_TX_ROUND_EN
      exp_a = 4; exp_b = 1447;
`else
      exp_a = 3; exp_b = 1446;
`endif
      do_reset();
      tax = '{0, 1, 1023, 3, 4, 8};
      tay = '{0, 1, 1023, 4, 5, 4};
      tox = 3; toy = 4;
      load_all();
      pulse_start();
      tick(72);
      run_window("dist_small", 0);
      n_checks++;
      if (cap_r[0] != 5 || cap_r[1] != exp_a || cap_r[3] != 0) begin
         n_fail++;
         $display("FAIL dist_known: got R0=%0d R1=%0d R3=%0d, expected 5 %0d 0",
                  cap_r[0], cap_r[1], cap_r[3], exp_a);
      end
      do_reset();
      tax = '{0, 1023, 0, 1023, 512, 17};
      tay = '{0, 0, 1023, 1023, 700, 999};
      tox = 1023; toy = 1023;
      load_all();
      pulse_start();
      tick(72);
      run_window("dist_max", 1);
      n_checks++;
      if (cap_r[0] != exp_b || cap_r[3] != 0) begin
         n_fail++;
         $display("FAIL dist_max_known: got R0=%0d R3=%0d, expected %0d 0",
                  cap_r[0], cap_r[3], exp_b);
      end
   endtask

   task automatic test_full_run();
      do_reset();
      tax = '{100, 300, 400, 300, 100, 0};
      tay = '{100, 100, 273, 446, 446, 273};
      tox = 200; toy = 273;
      load_all();
      pulse_start();
      tick(72);
      run_window("full_inside", 2);
      n_checks++;
      if (result_inside !== 1'b1) begin
         n_fail++;
         $display("FAIL full_inside_verdict: got %b, expected 1", result_inside);
      end
      tox = 900; toy = 900;
      wr_en = 1'b1; wr_idx = 3'd6; wr_x = 10'd900; wr_y = 10'd900;
      tick();
      wr_en = 1'b0;
      pulse_start();
      tick(72);
      run_window("full_outside", 2);
      n_checks++;
      if (result_inside !== 1'b0) begin
         n_fail++;
         $display("FAIL full_outside_verdict: got %b, expected 0", result_inside);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 3; it++) begin
         do_reset();
         for (int i = 0; i < 6; i++) begin
            tax[i] = int'($urandom_range(1023));
            tay[i] = int'($urandom_range(1023));
         end
         tox = int'($urandom_range(1023));
         toy = int'($urandom_range(1023));
         load_all();
         pulse_start();
         tick(72);
         run_window($sformatf("random%0d", it), int'($urandom_range(1)));
      end
   endtask

   task automatic test_armed_entry();
      do_reset();
      tax = '{10, 20, 30, 40, 50, 60};
      tay = '{65, 55, 45, 35, 25, 15};
      tox = 33; toy = 44;
      load_all();
      pulse_start();
      tick(71);
      fence_valid = 1'b1;
      tick();
      fence_valid = 1'b0;
      n_checks++;
      if (X !== 10'd0 || R !== 11'd0) begin
         n_fail++;
         $display("FAIL entry_edge_pulse: got X=%0d R=%0d, expected 0 0", X, R);
      end
      tick();
      n_checks++;
      if (X !== 10'd0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL entry_edge_after: got X=%0d busy=%b, expected 0 1", X, busy);
      end
      run_window("after_entry", 1);
   endtask

   task automatic test_ownership();
      do_reset();
      tax = '{5, 900, 77, 300, 1000, 640};
      tay = '{800, 12, 512, 300, 1000, 3};
      tox = 400; toy = 400;
      load_all();
      pulse_start();
      tick(29);
      fence_valid = 1'b1;
      tick();
      fence_valid = 1'b0;
      n_checks++;
      if (X !== 10'd0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL foreign_valid: got X=%0d busy=%b, expected 0 1", X, busy);
      end
      tick(42);
      run_window("ownership", 0);
   endtask

   task automatic test_busy_guard();
      do_reset();
      tax = '{111, 222, 333, 444, 555, 666};
      tay = '{600, 500, 400, 300, 200, 100};
      tox = 250; toy = 350;
      load_all();
      pulse_start();
      tick(20);
      wr_en = 1'b1; wr_idx = 3'd0; wr_x = 10'd7; wr_y = 10'd9; start = 1'b1;
      tick();
      wr_idx = 3'd6; wr_x = 10'd1000; wr_y = 10'd1000; start = 1'b0;
      tick();
      wr_en = 1'b0;
      tick(50);
      run_window("busy_guard", 1);
   endtask

   task automatic test_reset_mid_send();
      do_reset();
      tax = '{40, 80, 120, 160, 200, 240};
      tay = '{15, 25, 35, 45, 55, 65};
      tox = 0; toy = 1000;
      load_all();
      pulse_start();
      tick(72);
      fence_valid = 1'b1;
      tick();
      fence_valid = 1'b0;
      tick(3);
      n_checks++;
      if (X !== 10'(tax[3]) || Y !== 10'(tay[3])) begin
         n_fail++;
         $display("FAIL mid_send_slot3: got X=%0d Y=%0d, expected %0d %0d", X, Y, tax[3], tay[3]);
      end
      reset = 1'b0;
      tick();
      reset = 1'b1;
      n_checks++;
      if (X !== 10'd0 || Y !== 10'd0 || R !== 11'd0 || busy !== 1'b0 || result_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_send_reset: got X=%0d Y=%0d R=%0d busy=%b rv=%b, expected all 0",
                  X, Y, R, busy, result_valid);
      end
      for (int i = 0; i < 2; i++) begin
         fence_valid = 1'b1; fence_is_inside = 1'b1;
         tick();
         fence_valid = 1'b0; fence_is_inside = 1'b0;
         tick();
         n_checks++;
         if (result_valid !== 1'b0 || result_inside !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_valid%0d: got rv=%b ri=%b, expected 0 0",
                     i, result_valid, result_inside);
         end
      end
      load_all();
      pulse_start();
      tick(72);
      run_window("fresh_after_reset", 1);
   endtask

   initial begin
      test_reset();
      test_distance();
      test_full_run();
      test_random();
      test_armed_entry();
      test_ownership();
      test_busy_guard();
      test_reset_mid_send();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
